// File: rtl/unified_mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory between the
// instruction-fetch port and the data port, one outstanding access at a time.
module unified_mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2
    } state_t;

    state_t     state;
    logic       last_winner;   // 1 = data port won the most recent contention
    logic       owner_data;    // port that owns the access in flight
    logic [2:0] lat_cnt;
    logic       pick_data;

    // Under contention the port that did not win last time goes first.
    assign pick_data = d_req && (!if_req || !last_winner);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_winner <= 1'b1;
            owner_data  <= 1'b0;
            lat_cnt     <= 3'd0;
            if_gnt      <= 1'b0;
            if_rvalid   <= 1'b0;
            if_rdata    <= '0;
            d_gnt       <= 1'b0;
            d_rvalid    <= 1'b0;
            d_rdata     <= '0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
        end else begin
            if_gnt    <= 1'b0;
            d_gnt     <= 1'b0;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            case (state)
                IDLE: begin
                    if (if_req || d_req) begin
                        state      <= ACCESS;
                        owner_data <= pick_data;
                        mem_en     <= 1'b1;
                        if (pick_data) begin
                            mem_we    <= d_we;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            d_gnt     <= 1'b1;
                        end else begin
                            mem_addr <= if_addr;
                            if_gnt   <= 1'b1;
                        end
                        if (if_req && d_req) begin
                            last_winner <= pick_data;
                        end
                    end
                end
                ACCESS: begin
                    // mem_we still reflects the access being issued this cycle
                    if (mem_we) begin
                        state <= IDLE;
                    end else begin
                        state   <= WAIT;
                        lat_cnt <= 3'(MEM_LAT);
                    end
                end
                WAIT: begin
                    if (lat_cnt <= 3'd1) begin
                        state <= IDLE;
                        if (owner_data) begin
                            d_rdata  <= mem_rdata;
                            d_rvalid <= 1'b1;
                        end else begin
                            if_rdata  <= mem_rdata;
                            if_rvalid <= 1'b1;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
Shares one single-port synchronous unified memory between the core's instruction-fetch port and its data port.
- Serialises requests, one outstanding access at a time.
- Arbitrates round-robin under contention.
- Returns read data to the requester with a registered valid pulse.
- Sits between the 16-bit RISC core's imem/dmem ports and a single SRAM macro.

Parameters:
ADDR_W, 16, address width of all ports
DATA_W, 16, data width of all ports
MEM_LAT, 1, cycles from mem_en (read) to mem_rdata valid; legal 1..4

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request; held until if_gnt
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  fetch accepted (1-cycle pulse)
if_rvalid  out  1  fetch data valid (1-cycle pulse)
if_rdata  out  DATA_W  fetch data
d_req  in  1  data request; held until d_gnt
d_we  in  1  1=write, 0=read
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  write data
d_gnt  out  1  data request accepted (1-cycle pulse)
d_rvalid  out  1  data read valid (1-cycle pulse; never for writes)
d_rdata  out  DATA_W  data read result
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data
busy  out  1  state != IDLE

Behaviour:
- clk is the single clock; rst_n is asynchronous, active-low.
- Reset: state IDLE, last_winner=DATA (fetch wins first contention). All outputs 0: gnt, rvalid, mem_en, mem_we, busy, rdata, mem_addr, mem_wdata.
- FSM states: IDLE, ACCESS, WAIT.
- Arbitration happens only in IDLE; requests raised while busy wait until the next IDLE cycle.
- IDLE, cycle N:
  - Only one req set: that requester wins.
  - Both set: the requester that is not last_winner wins; last_winner updates.
  - Winner's addr/we/wdata are registered. Next state ACCESS.
  - If fetch wins, it is a read.
- ACCESS, cycle N+1:
  - mem_en=1; mem_we/mem_addr/mem_wdata driven from registers.
  - Winner's gnt=1 for this cycle only.
  - Write: next state IDLE. No rvalid.
  - Read: next state WAIT; latency counter loaded with MEM_LAT.
- WAIT:
  - Counter decrements each cycle.
  - When mem_rdata is valid (cycle N+1+MEM_LAT), it is captured into the winner's rdata register.
  - Winner's rvalid=1 at cycle N+2+MEM_LAT; the FSM is IDLE in that same cycle and may arbitrate.
- Throughput: read = MEM_LAT+2 cycles issue-to-issue; write = 2 cycles.
- rdata holds its last value after rvalid drops. The non-winning rdata is unchanged.
- Requester may drop or change req/addr from the cycle after gnt; the arbiter has already sampled them.
- req dropped before being sampled in IDLE: no access, no gnt.
- mem_en/mem_we are 0 in IDLE and WAIT. mem_addr/mem_wdata hold their last values.
- Reset asserted mid-access (ACCESS or WAIT): immediate return to reset values; in-flight read discarded, no rvalid ever issued for it.
- Requesters still holding req after reset release are served as new requests.
- busy=1 in ACCESS and WAIT.

Test Plan:
1. MEM_LAT=1; if_req at cycle 0, if_addr=0x0004; memory returns 0xA5A5 at cycle 2 -> if_gnt, mem_en=1, mem_addr=0x0004, mem_we=0 at cycle 1; if_rvalid=1, if_rdata=0xA5A5 at cycle 3; busy=1 on cycles 1-2.
2. d_req, d_we=1, d_addr=0x0010, d_wdata=0x1234 at cycle 0 -> cycle 1: mem_en=1, mem_we=1, mem_addr=0x0010, mem_wdata=0x1234, d_gnt=1; d_rvalid never asserted; busy=0 from cycle 2.
3. After reset, if_req and d_req (read 0x0020) both held from cycle 0 -> fetch granted at cycle 1, if_rvalid at 3; d_gnt at cycle 4, d_rvalid at 6. Repeat with both held -> strict alternation, data wins next contention.
4. MEM_LAT=3, d read 0x00FF, memory returns 0xBEEF at cycle 4 -> d_gnt at 1, d_rvalid=1 with d_rdata=0xBEEF at cycle 5, busy on cycles 1-4.
5. MEM_LAT=3; fetch read granted at cycle 1; rst_n low at cycle 3 for 2 cycles with if_req still high -> outputs 0 immediately, no if_rvalid for the aborted read; new if_gnt one cycle after first IDLE cycle following release.
6. d_req raised at cycle 2 while a fetch read (MEM_LAT=1) is in WAIT -> d_req not granted before cycle 4; d_gnt at cycle 4; mem_en never asserted during WAIT.
